// File: rtl/rd_id_tracker_pkg.sv
// Shared types and sizing for the rd/ID tracking slice.
package rd_id_tracker_pkg;

  localparam int unsigned MAX_IDS            = 8;
  localparam int unsigned ID_W               = $clog2(MAX_IDS);
  localparam int unsigned COMMIT_PORTS       = 2;
  localparam int unsigned REGFILE_READ_PORTS = 2;
  localparam int unsigned RS_ADDR_W          = 5;
  localparam int unsigned NUM_REGS           = 1 << RS_ADDR_W;

  typedef logic [ID_W-1:0]      id_t;
  typedef logic [RS_ADDR_W-1:0] rs_addr_t;

endpackage

// File: rtl/rd_id_tracker_if.sv
// Issue/retire/lookup bundle between the issue stage and the tracker.
interface rd_id_tracker_if;
  import rd_id_tracker_pkg::*;

  logic                                     issue_valid;
  id_t                                      issue_id;
  rs_addr_t                                 issue_rd_addr;
  logic                                     issue_uses_rd;
  rs_addr_t [REGFILE_READ_PORTS-1:0]        issue_rs_addr;
  logic     [REGFILE_READ_PORTS-1:0]        rs_pending;
  id_t      [COMMIT_PORTS-1:0]              ids_retiring;
  logic     [COMMIT_PORTS-1:0]              retired;
  rs_addr_t [COMMIT_PORTS-1:0]              retired_rd_addr;
  id_t      [COMMIT_PORTS-1:0]              id_for_rd;
  logic                                     flush;

  modport master (
    output issue_valid, issue_id, issue_rd_addr, issue_uses_rd, issue_rs_addr,
    output ids_retiring, retired, flush,
    input  rs_pending, retired_rd_addr, id_for_rd
  );

  modport slave (
    input  issue_valid, issue_id, issue_rd_addr, issue_uses_rd, issue_rs_addr,
    input  ids_retiring, retired, flush,
    output rs_pending, retired_rd_addr, id_for_rd
  );

endinterface

// File: rtl/rd_id_tracker_scoreboard.sv
// Per-register pending bits: issue sets, matching retires clear, flush wipes.
module rd_scoreboard
  import rd_id_tracker_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 set_valid_i,
  input  rs_addr_t                             set_addr_i,
  input  logic     [COMMIT_PORTS-1:0]          clr_valid_i,
  input  rs_addr_t [COMMIT_PORTS-1:0]          clr_addr_i,
  input  logic                                 flush_i,
  input  rs_addr_t [REGFILE_READ_PORTS-1:0]    rd_addr_i,
  output logic     [REGFILE_READ_PORTS-1:0]    pending_o
);

  logic [NUM_REGS-1:0] rd_pending_q;
  logic [NUM_REGS-1:0] rd_pending_d;

  // Next pending state: flush beats everything, a new issue beats a clear on the same rd.
  always_comb begin
    rd_pending_d = rd_pending_q;
    if (flush_i) begin
      rd_pending_d = '0;
    end else begin
      for (int i = 0; i < COMMIT_PORTS; i++) begin
        if (clr_valid_i[i] && (clr_addr_i[i] != '0)) begin
          rd_pending_d[clr_addr_i[i]] = 1'b0;
        end
      end
      if (set_valid_i && (set_addr_i != '0)) begin
        rd_pending_d[set_addr_i] = 1'b1;
      end
    end
  end

  // Pending state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending_q <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
    end
  end

  // Read ports see registered state only; x0 is never pending.
  always_comb begin
    pending_o = '0;
    for (int j = 0; j < REGFILE_READ_PORTS; j++) begin
      pending_o[j] = (rd_addr_i[j] == '0) ? 1'b0 : rd_pending_q[rd_addr_i[j]];
    end
  end

endmodule

// File: rtl/rd_id_tracker.sv
// ID<->rd tables for writeback plus the RAW pending scoreboard for issue.
module rd_id_tracker
  import rd_id_tracker_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rd_id_tracker_if.slave bus
);

  rs_addr_t id_to_rd_q [MAX_IDS];
  rs_addr_t id_to_rd_d [MAX_IDS];
  id_t      rd_to_id_q [NUM_REGS];
  id_t      rd_to_id_d [NUM_REGS];

  rs_addr_t [COMMIT_PORTS-1:0] ret_rd;
  id_t      [COMMIT_PORTS-1:0] ret_newest;
  logic     [COMMIT_PORTS-1:0] ret_clr;
  logic                        issue_sets_rd;

  // Retire lookup on pre-edge tables; a port clears pending only if it is the newest writer.
  always_comb begin
    ret_rd     = '0;
    ret_newest = '0;
    ret_clr    = '0;
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      ret_rd[i]     = id_to_rd_q[bus.ids_retiring[i]];
      ret_newest[i] = rd_to_id_q[ret_rd[i]];
      ret_clr[i]    = bus.retired[i] && (ret_newest[i] == bus.ids_retiring[i]) &&
                      (ret_rd[i] != '0);
    end
  end

  assign bus.retired_rd_addr = ret_rd;
  assign bus.id_for_rd       = ret_newest;
  assign issue_sets_rd       = bus.issue_valid && bus.issue_uses_rd;

  // Table updates at issue; flush does not touch these tables.
  always_comb begin
    id_to_rd_d = id_to_rd_q;
    rd_to_id_d = rd_to_id_q;
    if (bus.issue_valid) begin
      id_to_rd_d[bus.issue_id] = bus.issue_uses_rd ? bus.issue_rd_addr : '0;
      if (bus.issue_uses_rd && (bus.issue_rd_addr != '0)) begin
        rd_to_id_d[bus.issue_rd_addr] = bus.issue_id;
      end
    end
  end

  // Table registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_IDS; k++) begin
        id_to_rd_q[k] <= '0;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        rd_to_id_q[r] <= '0;
      end
    end else begin
      id_to_rd_q <= id_to_rd_d;
      rd_to_id_q <= rd_to_id_d;
    end
  end

  rd_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_valid_i (issue_sets_rd),
    .set_addr_i  (bus.issue_rd_addr),
    .clr_valid_i (ret_clr),
    .clr_addr_i  (ret_rd),
    .flush_i     (bus.flush),
    .rd_addr_i   (bus.issue_rs_addr),
    .pending_o   (bus.rs_pending)
  );

endmodule

// File: tb/tb_rd_id_tracker.sv
// Directed scenarios plus random traffic against a table-level reference model.
module tb_rd_id_tracker;
  import rd_id_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rd_id_tracker_if bus ();

  rd_id_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: who writes which register, who is newest, what is outstanding.
  int m_dest   [MAX_IDS];
  int m_newest [NUM_REGS];
  bit m_busy   [NUM_REGS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_id      = '0;
    bus.issue_rd_addr = '0;
    bus.issue_uses_rd = 1'b0;
    bus.retired       = '0;
    bus.ids_retiring  = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic issue(input int id, input int rd);
    bus.issue_valid   = 1'b1;
    bus.issue_id      = id_t'(id);
    bus.issue_rd_addr = rs_addr_t'(rd);
    bus.issue_uses_rd = 1'b1;
  endtask

  task automatic retire(input int port, input int id);
    bus.retired[port]      = 1'b1;
    bus.ids_retiring[port] = id_t'(id);
  endtask

  // Compare all combinational outputs against the model's current (pre-edge) state.
  task automatic check_outputs();
    int a;
    int d;
    for (int j = 0; j < REGFILE_READ_PORTS; j++) begin
      a = int'(bus.issue_rs_addr[j]);
      chk($sformatf("rs_pending[%0d]", j), 32'(bus.rs_pending[j]),
          (a == 0) ? 32'd0 : 32'(m_busy[a]));
    end
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      d = m_dest[int'(bus.ids_retiring[i])];
      chk($sformatf("retired_rd_addr[%0d]", i), 32'(bus.retired_rd_addr[i]), 32'(d));
      chk($sformatf("id_for_rd[%0d]", i), 32'(bus.id_for_rd[i]), 32'(m_newest[d]));
    end
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    int d   [COMMIT_PORTS];
    int nw  [COMMIT_PORTS];
    int rd;
    if (rst) begin
      foreach (m_dest[k])   m_dest[k]   = 0;
      foreach (m_newest[r]) m_newest[r] = 0;
      foreach (m_busy[r])   m_busy[r]   = 0;
      return;
    end
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      d[i]  = m_dest[int'(bus.ids_retiring[i])];
      nw[i] = m_newest[d[i]];
    end
    rd = int'(bus.issue_rd_addr);
    if (bus.flush) begin
      foreach (m_busy[r]) m_busy[r] = 0;
    end else begin
      for (int i = 0; i < COMMIT_PORTS; i++)
        if (bus.retired[i] && nw[i] == int'(bus.ids_retiring[i]) && d[i] != 0)
          m_busy[d[i]] = 0;
      if (bus.issue_valid && bus.issue_uses_rd && rd != 0) m_busy[rd] = 1;
    end
    if (bus.issue_valid) begin
      m_dest[int'(bus.issue_id)] = bus.issue_uses_rd ? rd : 0;
      if (bus.issue_uses_rd && rd != 0) m_newest[rd] = int'(bus.issue_id);
    end
  endtask

  task automatic mid();
    #4;
    check_outputs();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.issue_rs_addr = '0;
    repeat (2) edge_step();
    rst = 1'b0;
    bus.issue_rs_addr[0] = rs_addr_t'(5);
    bus.issue_rs_addr[1] = rs_addr_t'(7);
    mid();
    chk("reset_pend0", 32'(bus.rs_pending[0]), 32'd0);
    chk("reset_rra0", 32'(bus.retired_rd_addr[0]), 32'd0);
    edge_step();

    // 1: basic issue, retire, clear
    idle(); issue(3, 5); mid(); edge_step();
    idle(); mid(); chk("tp1_pend_set", 32'(bus.rs_pending[0]), 32'd1); edge_step();
    idle(); retire(0, 3); mid();
    chk("tp1_rra", 32'(bus.retired_rd_addr[0]), 32'd5);
    chk("tp1_ifr", 32'(bus.id_for_rd[0]), 32'd3);
    edge_step();
    idle(); mid(); chk("tp1_pend_clr", 32'(bus.rs_pending[0]), 32'd0); edge_step();

    // 2: older writer retiring does not clear
    idle(); issue(1, 7); mid(); edge_step();
    idle(); issue(2, 7); mid(); edge_step();
    idle(); retire(1, 1); bus.issue_rs_addr[0] = rs_addr_t'(7); mid();
    chk("tp2_ifr_mismatch", 32'(bus.id_for_rd[1]), 32'd2);
    edge_step();
    idle(); mid(); chk("tp2_pend_held", 32'(bus.rs_pending[0]), 32'd1); edge_step();
    idle(); retire(0, 2); mid(); edge_step();
    idle(); mid(); chk("tp2_pend_clr", 32'(bus.rs_pending[0]), 32'd0); edge_step();

    // 3: rd=0 writer
    idle(); issue(4, 0); mid(); edge_step();
    idle(); bus.issue_rs_addr[0] = '0; retire(0, 4); mid();
    chk("tp3_pend_x0", 32'(bus.rs_pending[0]), 32'd0);
    chk("tp3_rra_x0", 32'(bus.retired_rd_addr[0]), 32'd0);
    edge_step();

    // 4: issue and retire on the same rd in one cycle
    idle(); issue(5, 9); mid(); edge_step();
    idle(); issue(6, 9); retire(0, 5); mid();
    chk("tp4_ifr_old", 32'(bus.id_for_rd[0]), 32'd5);
    edge_step();
    idle(); bus.issue_rs_addr[0] = rs_addr_t'(9); retire(1, 6); mid();
    chk("tp4_pend_kept", 32'(bus.rs_pending[0]), 32'd1);
    chk("tp4_ifr_new", 32'(bus.id_for_rd[1]), 32'd6);
    edge_step();

    // 5: two ports retiring to the same rd
    idle(); issue(2, 12); mid(); edge_step();
    idle(); issue(3, 12); mid(); edge_step();
    idle(); retire(0, 2); retire(1, 3); bus.issue_rs_addr[0] = rs_addr_t'(12); mid();
    chk("tp5_ifr0", 32'(bus.id_for_rd[0]), 32'd3);
    chk("tp5_ifr1", 32'(bus.id_for_rd[1]), 32'd3);
    edge_step();
    idle(); mid(); chk("tp5_pend_clr", 32'(bus.rs_pending[0]), 32'd0); edge_step();

    // 6: flush with a concurrent issue, then reset mid-sequence
    for (int k = 0; k < 4; k++) begin
      idle(); issue(k, k + 1); mid(); edge_step();
    end
    idle(); bus.issue_rs_addr[0] = rs_addr_t'(1); bus.issue_rs_addr[1] = rs_addr_t'(4); mid();
    chk("tp6_pend1", 32'(bus.rs_pending[0]), 32'd1);
    chk("tp6_pend4", 32'(bus.rs_pending[1]), 32'd1);
    bus.flush = 1'b1; issue(5, 6); edge_step();
    idle(); bus.issue_rs_addr[0] = rs_addr_t'(6); retire(0, 5); mid();
    chk("tp6_flush_pend6", 32'(bus.rs_pending[0]), 32'd0);
    chk("tp6_flush_pend4", 32'(bus.rs_pending[1]), 32'd0);
    chk("tp6_flush_keeps_tbl", 32'(bus.retired_rd_addr[0]), 32'd6);
    edge_step();
    idle(); issue(7, 20); rst = 1'b1; mid(); edge_step();
    rst = 1'b0; idle(); bus.issue_rs_addr[0] = rs_addr_t'(20); retire(0, 3); mid();
    chk("tp6_rst_pend", 32'(bus.rs_pending[0]), 32'd0);
    chk("tp6_rst_rra", 32'(bus.retired_rd_addr[0]), 32'd0);
    chk("tp6_rst_ifr", 32'(bus.id_for_rd[0]), 32'd0);
    edge_step();

    // Random traffic; small rd range half the time to force collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.issue_valid = $urandom_range(0, 1) == 1;
      bus.issue_id = id_t'($urandom_range(0, MAX_IDS - 1));
      bus.issue_uses_rd = $urandom_range(0, 3) != 0;
      bus.issue_rd_addr = ($urandom_range(0, 1) == 1) ? rs_addr_t'($urandom_range(0, 3))
                                                      : rs_addr_t'($urandom_range(0, 31));
      for (int i = 0; i < COMMIT_PORTS; i++) begin
        bus.retired[i] = $urandom_range(0, 1) == 1;
        bus.ids_retiring[i] = id_t'($urandom_range(0, MAX_IDS - 1));
      end
      for (int j = 0; j < REGFILE_READ_PORTS; j++)
        bus.issue_rs_addr[j] = ($urandom_range(0, 1) == 1) ? rs_addr_t'($urandom_range(0, 3))
                                                           : rs_addr_t'($urandom_range(0, 31));
      mid();
      edge_step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
